lenet_frame_sched: RTL and testbench

Batch scheduler for the lenet core. It sequences a run of N frames through lenet by pulsing go once per frame and waiting for ready. It relocates lenet's 12-bit frame-relative ROM address onto a per-frame base in the shared source ROM. Each classified digit is captured, tagged with its frame index, and queued in a small result FIFO for the host.

---
 rtl/lenet_frame_sched.sv | 190 +++++++++++++++++++
 tb/tb_lenet_frame_sched.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lenet_frame_sched.sv
// Batch scheduler for the lenet core: issues one go per frame, relocates the
// frame-relative ROM address onto a per-frame base, and queues tagged results.
module lenet_frame_sched #(
    parameter int unsigned AW          = 16,
    parameter int unsigned FRAME_WORDS = 1024,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned TIMEOUT     = 1048576
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic [7:0]    num_frames,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          timeout_err,
    output logic [7:0]    frames_done,
    output logic          lenet_go,
    input  logic          lenet_ready,
    input  logic [5:0]    lenet_digit,
    input  logic [11:0]   lenet_aa,
    input  logic          lenet_cena,
    output logic [AW-1:0] rom_aa,
    output logic          rom_cena,
    output logic          res_valid,
    output logic [5:0]    res_digit,
    output logic [7:0]    res_frame,
    input  logic          res_pop
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [TW-1:0] TLAST_C   = TW'(TIMEOUT - 1);
    localparam logic [AW-1:0] STRIDE_C  = AW'(FRAME_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GO,
        S_WAIT,
        S_STALL,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      n_q, n_d;
    logic [7:0]      idx_q, idx_d;
    logic [7:0]      fdone_q, fdone_d;
    logic [AW-1:0]   base_q, base_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            terr_q, terr_d;
    logic [13:0]     held_q, held_d;

    logic [13:0]     mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wptr_q, rptr_q;
    logic [CW-1:0]   cnt_q;

    logic            abort_act;
    logic            fifo_space;
    logic            push;
    logic [13:0]     push_data;
    logic            pop;
    logic            advance;

    assign abort_act  = abort && (state_q != S_IDLE);
    assign fifo_space = (cnt_q != DEPTH_C) || res_pop;
    assign pop        = res_pop && (cnt_q != '0);

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        idx_d     = idx_q;
        fdone_d   = fdone_q;
        base_d    = base_q;
        timer_d   = timer_q;
        terr_d    = terr_q;
        held_d    = held_q;
        push      = 1'b0;
        push_data = held_q;
        advance   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_d     = num_frames;
                    idx_d   = '0;
                    fdone_d = '0;
                    base_d  = '0;
                    terr_d  = 1'b0;
                    state_d = (num_frames != '0) ? S_GO : S_DONE;
                end
            end
            S_GO: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                timer_d = timer_q + 1'b1;
                if (lenet_ready) begin
                    held_d = {idx_q, lenet_digit};
                    if (fifo_space) begin
                        push      = 1'b1;
                        push_data = {idx_q, lenet_digit};
                        advance   = 1'b1;
                    end else begin
                        state_d = S_STALL;
                    end
                end else if (timer_q == TLAST_C) begin
                    terr_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_STALL: begin
                if (fifo_space) begin
                    push    = 1'b1;
                    advance = 1'b1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (advance && !abort_act) begin
            idx_d   = idx_q + 8'd1;
            fdone_d = fdone_q + 8'd1;
            base_d  = base_q + STRIDE_C;
            state_d = ((idx_q + 8'd1) == n_q) ? S_DONE : S_GO;
        end

        // Abort drops any result in flight and leaves counters as they were.
        if (abort_act) begin
            state_d = S_IDLE;
            terr_d  = terr_q;
            push    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            idx_q   <= '0;
            fdone_q <= '0;
            base_q  <= '0;
            timer_q <= '0;
            terr_q  <= 1'b0;
            held_q  <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            fdone_q <= fdone_d;
            base_q  <= base_d;
            timer_q <= timer_d;
            terr_q  <= terr_d;
            held_q  <= held_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            if (push && !pop)      cnt_q <= cnt_q + 1'b1;
            else if (pop && !push) cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= push_data;
    end

    assign busy        = (state_q != S_IDLE);
    // Strobes are masked by abort so a cancelled cycle never emits go or done.
    assign done        = (state_q == S_DONE) && !abort;
    assign lenet_go    = (state_q == S_GO) && !abort;
    assign timeout_err = terr_q;
    assign frames_done = fdone_q;
    assign rom_aa      = base_q + {{(AW-12){1'b0}}, lenet_aa};
    assign rom_cena    = (state_q == S_GO || state_q == S_WAIT || state_q == S_STALL)
                         ? lenet_cena : 1'b1;
    assign res_valid   = (cnt_q != '0);
    assign {res_frame, res_digit} = mem_q[rptr_q];

endmodule

// File: tb/tb_lenet_frame_sched.sv
// Scoreboard bench for lenet_frame_sched: lenet behaviour is driven inline,
// expected FIFO entries are queued at ready time and checked on each pop.
module tb_lenet_frame_sched;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  num_frames = '0;
    logic        abort = 1'b0;
    logic        lenet_ready = 1'b0;
    logic [5:0]  lenet_digit = '0;
    logic [11:0] lenet_aa = '0;
    logic        lenet_cena = 1'b1;
    logic        res_pop = 1'b0;

    logic        busy, done, timeout_err, lenet_go, rom_cena, res_valid;
    logic [7:0]  frames_done, res_frame;
    logic [5:0]  res_digit;
    logic [15:0] rom_aa;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned done_cnt = 0;
    int unsigned go_cnt = 0;
    int unsigned d0, g0;
    logic [13:0] sb [$];
    logic [13:0] mon_e;
    logic [5:0]  t1_dig [3];

    lenet_frame_sched #(
        .AW(16),
        .FRAME_WORDS(1024),
        .FIFO_DEPTH(4),
        .TIMEOUT(64)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .num_frames(num_frames),
        .abort(abort), .busy(busy), .done(done), .timeout_err(timeout_err),
        .frames_done(frames_done), .lenet_go(lenet_go),
        .lenet_ready(lenet_ready), .lenet_digit(lenet_digit),
        .lenet_aa(lenet_aa), .lenet_cena(lenet_cena),
        .rom_aa(rom_aa), .rom_cena(rom_cena), .res_valid(res_valid),
        .res_digit(res_digit), .res_frame(res_frame), .res_pop(res_pop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    // Called during a GO cycle; returns #1 into the cycle after the ready strobe.
    task automatic serve(input logic [7:0] frame, input logic [5:0] digit, input int unsigned lat);
        cyc(lat);
        lenet_ready = 1'b1;
        lenet_digit = digit;
        sb.push_back({frame, digit});
        cyc(1);
        lenet_ready = 1'b0;
        #1;
    endtask

    task automatic launch(input logic [7:0] n);
        cyc(1);
        start = 1'b1;
        num_frames = n;
        cyc(1);
        start = 1'b0;
        num_frames = 8'hAA;
        #1;
    endtask

    always @(negedge clk) begin
        #2;
        if (rstn) begin
            if (done) done_cnt++;
            if (lenet_go) go_cnt++;
            if (res_valid && res_pop) begin
                if (sb.size() == 0) begin
                    check("pop_unexpected", sb.size(), 1);
                end else begin
                    mon_e = sb.pop_front();
                    check("res_frame", res_frame, mon_e[13:6]);
                    check("res_digit", res_digit, mon_e[5:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        t1_dig[0] = 6'd7; t1_dig[1] = 6'd2; t1_dig[2] = 6'd9;
        lenet_aa = 12'd5;

        cyc(2); #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_go", lenet_go, 0);
        check("rst_terr", timeout_err, 0);
        check("rst_valid", res_valid, 0);
        check("rst_fdone", frames_done, 0);
        check("rst_cena", rom_cena, 1);
        check("rst_rom_aa", rom_aa, 5);
        cyc(1);
        rstn = 1'b1;

        // 1: three frames, continuous draining
        res_pop = 1'b1;
        lenet_cena = 1'b0;
        d0 = done_cnt;
        launch(8'd3);
        check("t1_go_T+1", lenet_go, 1);
        for (int i = 0; i < 3; i++) begin
            check("t1_rom_aa", rom_aa, 5 + 1024 * i);
            check("t1_rom_cena", rom_cena, 0);
            serve(8'(i), t1_dig[i], 10);
            check("t1_res_valid", res_valid, 1);
            if (i < 2) check("t1_next_go", lenet_go, 1);
            else       check("t1_done", done, 1);
        end
        cyc(1); #1;
        check("t1_idle", busy, 0);
        check("t1_fdone", frames_done, 3);
        check("t1_done_cnt", done_cnt - d0, 1);
        check("t1_cena_idle", rom_cena, 1);
        check("t1_sb_drained", sb.size(), 0);

        // 2: zero-frame batch
        g0 = go_cnt;
        d0 = done_cnt;
        launch(8'd0);
        check("t2_done", done, 1);
        check("t2_busy", busy, 1);
        check("t2_go", lenet_go, 0);
        cyc(1); #1;
        check("t2_busy_off", busy, 0);
        check("t2_done_off", done, 0);
        cyc(2);
        check("t2_go_cnt", go_cnt - g0, 0);
        check("t2_done_cnt", done_cnt - d0, 1);
        check("t2_fdone", frames_done, 0);

        // 3: backpressure with a 4-entry FIFO
        res_pop = 1'b0;
        d0 = done_cnt;
        launch(8'd6);
        check("t3_go", lenet_go, 1);
        for (int i = 0; i < 4; i++) begin
            serve(8'(i), 6'(10 + i), 3);
            check("t3_next_go", lenet_go, 1);
        end
        serve(8'd4, 6'd20, 3);
        check("t3_stall_go", lenet_go, 0);
        check("t3_stall_busy", busy, 1);
        check("t3_stall_valid", res_valid, 1);
        check("t3_stall_fdone", frames_done, 4);
        g0 = go_cnt;
        cyc(5); #1;
        check("t3_no_go", go_cnt - g0, 0);
        check("t3_fdone_hold", frames_done, 4);
        cyc(1);
        res_pop = 1'b1;
        cyc(1);
        res_pop = 1'b0;
        #1;
        check("t3_go_after_pop", lenet_go, 1);
        check("t3_fdone5", frames_done, 5);
        serve(8'd5, 6'd21, 3);
        check("t3_stall2_go", lenet_go, 0);
        check("t3_stall2_fdone", frames_done, 5);
        cyc(1);
        res_pop = 1'b1;
        for (int k = 0; k < 20 && (sb.size() != 0 || busy); k++) cyc(1);
        #1;
        check("t3_sb_drained", sb.size(), 0);
        check("t3_fdone6", frames_done, 6);
        check("t3_idle", busy, 0);
        check("t3_done_cnt", done_cnt - d0, 1);

        // 4: timeout after 64 WAIT cycles
        launch(8'd2);
        check("t4_go", lenet_go, 1);
        cyc(64); #1;
        check("t4_last_wait_done", done, 0);
        check("t4_last_wait_terr", timeout_err, 0);
        cyc(1); #1;
        check("t4_done", done, 1);
        check("t4_terr", timeout_err, 1);
        cyc(1); #1;
        check("t4_idle", busy, 0);
        check("t4_terr_sticky", timeout_err, 1);
        check("t4_fdone", frames_done, 0);
        launch(8'd1);
        check("t4_terr_clr", timeout_err, 0);
        check("t4_go2", lenet_go, 1);
        serve(8'd0, 6'd33, 5);
        check("t4_done2", done, 1);
        cyc(1);

        // 5: abort coinciding with ready of frame 1
        launch(8'd4);
        check("t5_go", lenet_go, 1);
        d0 = done_cnt;
        serve(8'd0, 6'd4, 4);
        check("t5_go1", lenet_go, 1);
        cyc(3);
        lenet_ready = 1'b1;
        lenet_digit = 6'd5;
        abort = 1'b1;
        cyc(1);
        lenet_ready = 1'b0;
        abort = 1'b0;
        #1;
        check("t5_busy", busy, 0);
        check("t5_go_off", lenet_go, 0);
        check("t5_cena", rom_cena, 1);
        check("t5_fdone", frames_done, 1);
        check("t5_no_done", done, 0);
        cyc(3); #1;
        check("t5_valid", res_valid, 0);
        check("t5_done_cnt", done_cnt - d0, 0);
        check("t5_sb_drained", sb.size(), 0);

        // 6: reset mid-WAIT with two queued entries
        res_pop = 1'b0;
        launch(8'd4);
        serve(8'd0, 6'd11, 3);
        serve(8'd1, 6'd12, 3);
        cyc(2); #1;
        check("t6_valid_before", res_valid, 1);
        check("t6_busy_before", busy, 1);
        cyc(1);
        rstn = 1'b0;
        #1;
        check("t6_busy", busy, 0);
        check("t6_valid", res_valid, 0);
        check("t6_fdone", frames_done, 0);
        check("t6_go", lenet_go, 0);
        check("t6_cena", rom_cena, 1);
        check("t6_rom_aa", rom_aa, 5);
        sb.delete();
        cyc(1);
        rstn = 1'b1;
        res_pop = 1'b1;
        launch(8'd1);
        check("t6_go2", lenet_go, 1);
        check("t6_base0", rom_aa, 5);
        serve(8'd0, 6'd42, 2);
        check("t6_done2", done, 1);
        cyc(2); #1;
        check("t6_fdone2", frames_done, 1);
        check("t6_sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
